imem_loader: RTL and testbench

Boot-time controller for the instruction SRAM inside the fetch stage. It receives a framed program image as a byte stream from the UART receiver and assembles the bytes into 32-bit words. It drives the SRAM write port (imem_din/imem_addr/imem_web) and holds the core in reset while loading. After a valid checksum it releases the core to execute from address 0.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/loader_timeout.sv | 36 +++
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and frame-format constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        RUN,
        ERR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTES_PER_WORD    = 4;
    localparam int         WORD_WIDTH        = 32;

    // States in which a frame is being received and the idle timeout runs.
    function automatic logic in_frame(input loader_state_t s);
        return (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-gap watchdog: reloads on clr, counts down while enabled, flags expiry at zero.
module loader_timeout #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image over a byte stream, writes it into the imem and
// holds the core in reset until the checksum has been verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [31:0] imem_din,
    output logic [31:0] imem_addr,
    output logic        imem_web,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int         IDX_W     = ADDR_WIDTH + 1;
    localparam logic [8:0] MAX_WORDS = 9'(1 << ADDR_WIDTH);

    loader_state_t   state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [23:0]     word_buf_q, word_buf_d;
    logic [7:0]      csum_q, csum_d;
    logic [WORD_WIDTH-1:0] imem_din_q, imem_din_d;
    logic [31:0]     imem_addr_q, imem_addr_d;
    logic            imem_web_q, imem_web_d;
    logic            core_rst_q, core_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            timeout_expired;
    logic [8:0]      words_written;

    loader_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_valid || !in_frame(state_q)),
        .en      (in_frame(state_q)),
        .expired (timeout_expired)
    );

    assign words_written = 9'(word_idx_q) + 9'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        word_buf_d  = word_buf_q;
        csum_d      = csum_q;
        imem_din_d  = imem_din_q;
        imem_addr_d = imem_addr_q;
        imem_web_d  = 1'b1;

        case (state_q)
            IDLE, RUN, ERR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d    = LEN;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    csum_d     = '0;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if ((rx_data == 8'h00) || ({1'b0, rx_data} > MAX_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        len_d   = rx_data;
                        csum_d  = csum_q ^ rx_data;
                        state_d = DATA;
                    end
                end else if (timeout_expired) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    csum_d = csum_q ^ rx_data;
                    case (byte_idx_q)
                        2'd0: word_buf_d[7:0]   = rx_data;
                        2'd1: word_buf_d[15:8]  = rx_data;
                        2'd2: word_buf_d[23:16] = rx_data;
                        default: begin
                            // Fourth byte completes the word; the write pulse is registered
                            // so the FSM keeps accepting bytes in the very next cycle.
                            imem_din_d  = {rx_data, word_buf_q};
                            imem_addr_d = 32'({word_idx_q[ADDR_WIDTH-1:0], 2'b00});
                            imem_web_d  = 1'b0;
                            word_idx_d  = word_idx_q + 1'b1;
                            if (words_written == {1'b0, len_q}) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                    byte_idx_d = byte_idx_q + 1'b1;
                end else if (timeout_expired) begin
                    state_d = ERR;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? RUN : ERR;
                end else if (timeout_expired) begin
                    state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase

        core_rst_d = (state_d != RUN);
        done_d     = (state_d == RUN);
        error_d    = (state_d == ERR);
        busy_d     = in_frame(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            word_buf_q  <= '0;
            csum_q      <= '0;
            imem_din_q  <= '0;
            imem_addr_q <= '0;
            imem_web_q  <= 1'b1;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_buf_q  <= word_buf_d;
            csum_q      <= csum_d;
            imem_din_q  <= imem_din_d;
            imem_addr_q <= imem_addr_d;
            imem_web_q  <= imem_web_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign imem_din  = imem_din_q;
    assign imem_addr = imem_addr_q;
    assign imem_web  = imem_web_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum/length errors, timeout,
// restart from RUN and asynchronous reset mid-frame.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] imem_din;
    logic [31:0] imem_addr;
    logic        imem_web;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int base;

    imem_loader #(
        .ADDR_WIDTH     (5),
        .TIMEOUT_CYCLES (16),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .imem_din  (imem_din),
        .imem_addr (imem_addr),
        .imem_web  (imem_web),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Every cycle with the write strobe low counts as one imem write.
    always @(negedge clk) begin
        if (!rst && (imem_web == 1'b0)) begin
            wr_cnt++;
            $display("write addr=0x%08h data=0x%08h", imem_addr, imem_din);
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Two-word frame 0x12345678, 0xDEADBEEF; good checksum is 0x28.
    task automatic send_frame(input logic [7:0] csum);
        send(8'hA5); send(8'h02);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send(csum);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2;
        chk32("rst_din", imem_din, 32'h0);
        chk32("rst_addr", imem_addr, 32'h0);
        chk1("rst_web", imem_web, 1'b1);
        chk1("rst_core_rst", core_rst, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Normal load with byte-per-cycle streaming.
        base = wr_cnt;
        send(8'hA5);
        chk1("t1_busy_after_sync", busy, 1'b1);
        send(8'h02); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk1("t1_w0_web", imem_web, 1'b0);
        chk32("t1_w0_din", imem_din, 32'h12345678);
        chk32("t1_w0_addr", imem_addr, 32'h0);
        send(8'hEF);
        chk1("t1_w0_web_release", imem_web, 1'b1);
        chk32("t1_w0_din_hold", imem_din, 32'h12345678);
        send(8'hBE); send(8'hAD); send(8'hDE);
        chk1("t1_w1_web", imem_web, 1'b0);
        chk32("t1_w1_din", imem_din, 32'hDEADBEEF);
        chk32("t1_w1_addr", imem_addr, 32'h4);
        chk1("t1_done_before_csum", done, 1'b0);
        send(8'h28);
        chk1("t1_done", done, 1'b1);
        chk1("t1_core_rst", core_rst, 1'b0);
        chk1("t1_busy_end", busy, 1'b0);
        chk1("t1_error", error, 1'b0);
        #1;
        chk32("t1_write_count", 32'(wr_cnt - base), 32'd2);

        // Bad checksum.
        do_reset();
        base = wr_cnt;
        send_frame(8'h29);
        chk1("t2_error", error, 1'b1);
        chk1("t2_core_rst", core_rst, 1'b1);
        chk1("t2_done", done, 1'b0);
        chk32("t2_din_kept", imem_din, 32'hDEADBEEF);
        #1;
        chk32("t2_write_count", 32'(wr_cnt - base), 32'd2);

        // Length out of range on both sides, then the largest legal length.
        do_reset();
        base = wr_cnt;
        send(8'hA5); send(8'h00);
        chk1("t3_len0_error", error, 1'b1);
        chk1("t3_len0_busy", busy, 1'b0);
        send(8'hA5);
        chk1("t3_err_exit_error", error, 1'b0);
        chk1("t3_err_exit_busy", busy, 1'b1);
        send(8'h21);
        chk1("t3_len21_error", error, 1'b1);
        #1;
        chk32("t3_write_count", 32'(wr_cnt - base), 32'd0);
        send(8'hA5); send(8'h20);
        chk1("t3_len20_busy", busy, 1'b1);
        chk1("t3_len20_error", error, 1'b0);

        // Idle timeout mid-word.
        do_reset();
        base = wr_cnt;
        send(8'hA5); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
        repeat (15) @(negedge clk);
        chk1("t4_no_error_at_15", error, 1'b0);
        chk1("t4_busy_at_15", busy, 1'b1);
        @(negedge clk);
        chk1("t4_error_at_16", error, 1'b1);
        chk1("t4_busy_at_16", busy, 1'b0);
        chk1("t4_core_rst", core_rst, 1'b1);
        #1;
        chk32("t4_write_count", 32'(wr_cnt - base), 32'd0);

        // Noise in IDLE, then a restart from RUN.
        do_reset();
        send(8'h00); send(8'hFF); send(8'h5A);
        chk1("t5_idle_busy", busy, 1'b0);
        chk1("t5_idle_error", error, 1'b0);
        chk1("t5_idle_done", done, 1'b0);
        send_frame(8'h28);
        chk1("t5_first_done", done, 1'b1);
        send(8'hA5);
        chk1("t5_restart_core_rst", core_rst, 1'b1);
        chk1("t5_restart_busy", busy, 1'b1);
        chk1("t5_restart_done", done, 1'b0);
        base = wr_cnt;
        send(8'h01); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        chk1("t5_reload_web", imem_web, 1'b0);
        chk32("t5_reload_din", imem_din, 32'h11223344);
        chk32("t5_reload_addr", imem_addr, 32'h0);
        send(8'h45);
        chk1("t5_reload_done", done, 1'b1);
        chk1("t5_reload_core_rst", core_rst, 1'b0);
        #1;
        chk32("t5_write_count", 32'(wr_cnt - base), 32'd1);

        // Asynchronous reset while a write strobe is active.
        do_reset();
        send(8'hA5); send(8'h02); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk1("t6_web_before_rst", imem_web, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk1("t6_async_web", imem_web, 1'b1);
        chk32("t6_async_din", imem_din, 32'h0);
        chk32("t6_async_addr", imem_addr, 32'h0);
        chk1("t6_async_core_rst", core_rst, 1'b1);
        chk1("t6_async_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(8'h28);
        chk1("t6_reload_done", done, 1'b1);
        chk32("t6_reload_din", imem_din, 32'hDEADBEEF);
        chk32("t6_reload_addr", imem_addr, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
